alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single 16-bit ALU (add/sub/mul, combinational, with zero flag) between two requesters: port 0 is the control unit and port 1 is the address/loop-counter unit. It accepts one operation at a time over a valid/ready handshake, using round-robin arbitration. It holds the ALU operands and opcode stable for an opcode-dependent number of cycles, which makes the multiply a multicycle path. It then registers the result and zero flag and returns them tagged with the requester ID.

Parameters:
WIDTH, 16, data width of operands and result.
ADD_LAT, 1, cycles the ALU inputs are held for add/sub before capture (min 1).
MUL_LAT, 3, cycles the ALU inputs are held for mul before capture (min 1).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_opcode  in  3  000 add, 001 sub, 010 mul.
req0_a  in  WIDTH  operand A.
req0_b  in  WIDTH  operand B.
req1_valid, req1_ready, req1_opcode, req1_a, req1_b  same as the requester 0 ports, for requester 1.
alu_a_bus  out  WIDTH  to ALU a_bus.
alu_b_bus  out  WIDTH  to ALU b_bus.
alu_opcode  out  3  to ALU opcode.
alu_accumulator  in  WIDTH  from ALU result.
alu_zero_flag  in  1  from ALU zero flag.
rsp_valid  out  1  one-cycle pulse: result available.
rsp_id  out  1  requester the result belongs to.
rsp_result  out  WIDTH  registered result.
rsp_zero  out  1  registered zero flag.
rsp_err  out  1  the opcode was illegal.
busy  out  1  high in every state other than IDLE.

Behaviour:
- One clock; reset is synchronous and active-high (clk, reset).
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - alu_a_bus=0, alu_b_bus=0, alu_opcode=000, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset mid-operation aborts the operation. No rsp_valid is produced for it.
- States: IDLE, HOLD, RESP.
- IDLE:
  - reqN_ready is combinational and only ever asserted here.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - Never assert both readys in the same cycle.
  - On acceptance (ready=1 and valid=1 at edge T):
    - Register the operands and opcode onto alu_* and store the ID.
    - Load the counter with the latency (ADD_LAT or MUL_LAT).
    - Update last_grant, then go to HOLD.
- HOLD:
  - alu_* stay constant throughout.
  - The counter decrements each cycle.
  - When the counter is 1, capture alu_accumulator into rsp_result and alu_zero_flag into rsp_zero at that edge, then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - In that IDLE cycle, ready may be asserted again, so back-to-back operations are possible.
- Latency:
  - Acceptance at edge T gives rsp_valid high during the cycle after edge T+LAT+1.
  - Add: rsp_valid is high in the 3rd cycle after the accept cycle.
  - Throughput: one operation every LAT+2 cycles.
- Illegal opcodes (011–111):
  - Accepted normally, but alu_opcode is forced to 000 with a=b=0.
  - Uses ADD_LAT.
  - Response: rsp_err=1, rsp_result=0, rsp_zero=1.
- rsp_id, rsp_result, rsp_zero and rsp_err hold their values until the next capture. They are only meaningful while rsp_valid=1.
- Arithmetic is performed by the ALU. The result is truncated to WIDTH, so sub wraps and mul keeps the low 16 bits. The arbiter does no arithmetic.
- A requester must keep valid, opcode and operands stable until it sees ready. Withdrawing valid is allowed and simply cancels the request.
- The responder cannot be stalled: no backpressure on the response.

Decomposition:
- A shared package (processor-wide) holds:
  - the opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010;
  - the arbiter state encoding (IDLE, HOLD, RESP);
  - the WIDTH default.
  The ALU and the control unit import the same constants.
- One natural sub-module: rr_arb2, a two-input round-robin grant with a last_grant register. It is combinational in its grant output and updates on accept.

Test Plan:
- After reset, only req0 valid: add 0x0003 + 0x0004 -> req0_ready in the first cycle; rsp_valid 3 cycles later with rsp_id=0, rsp_result=0x0007, rsp_zero=0, rsp_err=0.
- req1 sub 0x0005 − 0x0005 -> rsp_result=0x0000, rsp_zero=1. Also 0x0000 − 0x0001 -> 0xFFFF, zero=0.
- req0 mul 0x0100 × 0x0100 with MUL_LAT=3 -> alu_* stable for 3 cycles; rsp after 5 cycles with result 0x0000, zero=1 (truncated).
- Both requesters continuously valid for 4 operations -> grants alternate 0,1,0,1. Ready is never asserted in HOLD/RESP and never to both at once.
- Opcode 3'b111 on req1 -> alu_opcode=000 with zero operands; rsp_err=1, rsp_result=0, rsp_zero=1.
- reset pulsed during HOLD of a mul -> no rsp_valid follows. All outputs are at their reset values in the next cycle, and the next tie is granted to req0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared processor-wide constants: ALU opcodes, arbiter state encoding,
// default datapath width. The ALU and control unit import the same package.
package alu_arbiter_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Only add/sub/mul exist; anything else is turned into a harmless add of 0+0.
  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant. Grant is combinational from the requests;
// last_grant only moves when the granted request is actually accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       last_grant
);

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt = req;
    if (req[0] && req[1])
      gnt = last_grant ? 2'b01 : 2'b10;
  end

  // Remember the winner; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= 1'b1;
    else if (accept)
      last_grant <= gnt[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the control unit (port 0) and the
// address/loop-counter unit (port 1). Operands are held on the ALU buses for
// an opcode-dependent number of cycles (multi-cycle mul path), the result is
// then registered and returned with the requester id.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,

  output logic [WIDTH-1:0] alu_a_bus,
  output logic [WIDTH-1:0] alu_b_bus,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_accumulator,
  input  logic             alu_zero_flag,

  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  localparam int LAT_MAX = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int CW      = $clog2(LAT_MAX + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             id_q;
  logic             err_q;

  logic [1:0]       gnt;
  logic [1:0]       ready;
  logic             accept;
  logic             last_grant;
  logic             sel;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        ({req1_valid, req0_valid}),
    .accept     (accept),
    .gnt        (gnt),
    .last_grant (last_grant)
  );

  // Ready only in IDLE, and only to the single granted (hence valid) requester.
  always_comb begin
    ready  = (state == ST_IDLE) ? gnt : 2'b00;
    accept = |ready;
    sel    = gnt[1];
    sel_op = sel ? req1_opcode : req0_opcode;
    sel_a  = sel ? req1_a      : req0_a;
    sel_b  = sel ? req1_b      : req0_b;
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign busy       = (state != ST_IDLE);

  // Accept -> hold ALU inputs for LAT cycles -> capture -> one-cycle response.
  // rsp_valid is registered out of RESP, so it lands in the following IDLE
  // cycle where a new request can already be accepted (LAT+2 throughput).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      alu_a_bus  <= '0;
      alu_b_bus  <= '0;
      alu_opcode <= OP_ADD;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= (state == ST_RESP);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            id_q  <= sel;
            err_q <= !op_legal(sel_op);
            cnt   <= (sel_op == OP_MUL) ? CW'(MUL_LAT) : CW'(ADD_LAT);
            if (op_legal(sel_op)) begin
              alu_opcode <= sel_op;
              alu_a_bus  <= sel_a;
              alu_b_bus  <= sel_b;
            end else begin
              alu_opcode <= OP_ADD;
              alu_a_bus  <= '0;
              alu_b_bus  <= '0;
            end
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt == CW'(1)) begin
            rsp_id     <= id_q;
            rsp_err    <= err_q;
            rsp_result <= err_q ? '0 : alu_accumulator;
            rsp_zero   <= err_q | alu_zero_flag;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU hooked to its buses.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_opcode = '0, req1_opcode = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [W-1:0] alu_a_bus, alu_b_bus, alu_accumulator;
  logic [2:0]   alu_opcode;
  logic         alu_zero_flag;
  logic         rsp_valid, rsp_id, rsp_zero, rsp_err, busy;
  logic [W-1:0] rsp_result;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .ADD_LAT(1), .MUL_LAT(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a_bus(alu_a_bus), .alu_b_bus(alu_b_bus), .alu_opcode(alu_opcode),
    .alu_accumulator(alu_accumulator), .alu_zero_flag(alu_zero_flag),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU; illegal opcodes give garbage so forcing to add matters.
  logic [31:0] prod;
  always_comb begin
    prod = 32'(alu_a_bus) * 32'(alu_b_bus);
    case (alu_opcode)
      OP_ADD:  alu_accumulator = alu_a_bus + alu_b_bus;
      OP_SUB:  alu_accumulator = alu_a_bus - alu_b_bus;
      OP_MUL:  alu_accumulator = prod[W-1:0];
      default: alu_accumulator = 16'hDEAD;
    endcase
    alu_zero_flag = (alu_accumulator == '0);
  end

  typedef struct {
    logic         port;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zero;
    logic         err;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic port, input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (port) begin
      req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, found;
    logic legal;
    lat   = (v.op == OP_MUL) ? 3 : 1;
    legal = (v.op == OP_ADD) || (v.op == OP_SUB) || (v.op == OP_MUL);
    found = 0;
    @(negedge clk);
    set_req(v.port, 1'b1, v.op, v.a, v.b);
    #1;
    chk("ready_grant", 32'({req1_ready, req0_ready}), v.port ? 32'h2 : 32'h1);
    @(posedge clk);
    @(negedge clk);
    set_req(v.port, 1'b0, v.op, v.a, v.b);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (found == 0) begin
        if (rsp_valid) found = c;
        else begin
          chk("ready_while_busy", 32'({req1_ready, req0_ready}), 32'h0);
          if (c <= lat)
            chk("alu_hold", {13'd0, alu_opcode, alu_a_bus ^ alu_b_bus},
                {13'd0, legal ? v.op : 3'b000, legal ? (v.a ^ v.b) : 16'h0});
        end
      end
    end
    chk("latency", 32'(found), 32'(lat + 2));
    // re-sample at the response cycle is not possible after the loop, so the
    // fields are held and still valid here (they only change on next capture)
    chk("rsp_id",     32'(rsp_id),     32'(v.port));
    chk("rsp_result", 32'(rsp_result), 32'(v.res));
    chk("rsp_zero",   32'(rsp_zero),   32'(v.zero));
    chk("rsp_err",    32'(rsp_err),    32'(v.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int  ngr, nrsp, found;
    logic gr[4];

    tv[0] = '{1'b0, OP_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0};
    tv[1] = '{1'b1, OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
    tv[2] = '{1'b1, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    tv[3] = '{1'b0, OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0};
    tv[4] = '{1'b1, OP_MUL, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0};
    tv[5] = '{1'b1, 3'b111, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b1};
    tv[6] = '{1'b0, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};

    // reset state
    do_reset();
    #1;
    chk("rst_outputs", {rsp_valid, rsp_id, rsp_zero, rsp_err, busy, alu_opcode, rsp_result},
        32'h0);
    chk("rst_alu_bus", {alu_a_bus, alu_b_bus}, 32'h0);

    foreach (tv[i]) run_vec(tv[i]);

    // both requesters continuously valid: grants must alternate from port 0
    do_reset();
    set_req(1'b0, 1'b1, OP_ADD, 16'h0001, 16'h0001);
    set_req(1'b1, 1'b1, OP_ADD, 16'h0002, 16'h0002);
    ngr = 0; nrsp = 0;
    for (int c = 0; c < 40 && ngr < 4; c++) begin
      #1;
      chk("both_ready", 32'(req0_ready & req1_ready), 32'h0);
      if (busy) chk("ready_in_busy", 32'({req1_ready, req0_ready}), 32'h0);
      if (rsp_valid) begin
        chk("alt_rsp_id", 32'(rsp_id), 32'(nrsp % 2));
        chk("alt_rsp_res", 32'(rsp_result), (nrsp % 2) ? 32'h4 : 32'h2);
        nrsp++;
      end
      if (req0_ready | req1_ready) begin
        gr[ngr] = req1_ready;
        ngr++;
      end
      if (ngr < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 12 && nrsp < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("alt_rsp_id", 32'(rsp_id), 32'(nrsp % 2));
        nrsp++;
      end
    end
    chk("alt_grant_count", 32'(ngr), 32'd4);
    chk("alt_rsp_count", 32'(nrsp), 32'd4);
    for (int i = 0; i < 4; i++) chk("alt_grant_order", 32'(gr[i]), 32'(i % 2));

    // reset during the HOLD of a multiply aborts it
    @(negedge clk);
    set_req(1'b0, 1'b1, OP_MUL, 16'h0003, 16'h0005);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("mul_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_outputs", {rsp_valid, rsp_id, rsp_zero, rsp_err, busy, alu_opcode, rsp_result},
        32'h0);
    chk("abort_alu_bus", {alu_a_bus, alu_b_bus}, 32'h0);
    found = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) found++;
    end
    chk("abort_no_rsp", 32'(found), 32'h0);
    set_req(1'b0, 1'b1, OP_ADD, 16'h0001, 16'h0002);
    set_req(1'b1, 1'b1, OP_ADD, 16'h0003, 16'h0004);
    #1;
    chk("tie_after_reset", 32'({req1_ready, req0_ready}), 32'h1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1;
        chk("tie_rsp", {15'd0, rsp_id, rsp_result}, 32'h0000_0003);
      end
    end
    chk("tie_rsp_seen", 32'(found), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
